// File: rtl/averager_accumulator.sv
// Pipelined read-modify-write accumulator over a dual-port word memory, with hazard forwarding.
// Define AVERAGER_ACCUMULATOR_SATURATE_EN to clamp overflowing sums instead of wrapping them.
module averager_accumulator #(
  parameter int DATA_WIDTH = 14,
  parameter int ADDR_WIDTH = 13,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic                         din_valid,
  input  logic        [ADDR_WIDTH-1:0] addr,
  input  logic                         init,
  input  logic                         wen,
  input  logic        [ADDR_WIDTH-1:0] rd_addr,
  output logic        [ACC_WIDTH-1:0]  rd_data,
  input  logic                         overflow_clr,
  output logic                         overflow,
  output logic                         busy
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] mem [2**ADDR_WIDTH];

  logic                         run_q;
  logic                         accept;
  logic                         s0_valid, s1_valid, s2_valid;
  logic        [ADDR_WIDTH-1:0] s0_addr, s1_addr, s2_addr;
  logic signed [DATA_WIDTH-1:0] s0_din, s1_din;
  logic                         s0_init, s1_init;
  logic        [ACC_WIDTH-1:0]  mem_q;
  logic        [ACC_WIDTH-1:0]  s2_sum;
  logic        [ACC_WIDTH-1:0]  din_ext, operand, raw_sum, sum;
  logic                         sum_ovf;

  // Input handshake: a sample is taken on any rising edge where din_valid and wen
  // are both high; there is no ready, the pipeline never stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) run_q <= 1'b0;
    else         run_q <= 1'b1;
  end

  assign accept = din_valid & wen & run_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s0_valid <= 1'b0;
      s0_addr  <= '0;
      s0_din   <= '0;
      s0_init  <= 1'b0;
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_din   <= '0;
      s1_init  <= 1'b0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_sum   <= '0;
    end else begin
      s0_valid <= accept;
      s0_addr  <= addr;
      s0_din   <= din;
      s0_init  <= init;
      s1_valid <= s0_valid;
      s1_addr  <= s0_addr;
      s1_din   <= s0_din;
      s1_init  <= s0_init;
      s2_valid <= s1_valid;
      s2_addr  <= s1_addr;
      s2_sum   <= sum;
    end
  end

  assign din_ext = {{(ACC_WIDTH-DATA_WIDTH){s1_din[DATA_WIDTH-1]}}, s1_din};

  // The read for this sample happened on the edge its predecessor wrote, so a
  // back-to-back hit on the same word must take the predecessor's sum instead.
  assign operand = (s2_valid && (s2_addr == s1_addr)) ? s2_sum : mem_q;
  assign raw_sum = operand + din_ext;
  assign sum_ovf = !s1_init && (operand[ACC_WIDTH-1] == din_ext[ACC_WIDTH-1]) &&
                   (raw_sum[ACC_WIDTH-1] != operand[ACC_WIDTH-1]);

  always_comb begin
    sum = raw_sum;
    if (s1_init) begin
      sum = din_ext;
    end
`ifdef AVERAGER_ACCUMULATOR_SATURATE_EN
    else if (sum_ovf) begin
      sum = operand[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX;
    end
`endif
  end

  // Two read ports share one write port; tools replicate this into two block RAMs.
  always_ff @(posedge clk) begin
    if (s1_valid) mem[s1_addr] <= sum;
    mem_q <= mem[s0_addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rd_data <= '0;
    else         rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                  overflow <= 1'b0;
    else if (s1_valid && sum_ovf) overflow <= 1'b1;
    else if (overflow_clr)        overflow <= 1'b0;
  end

  assign busy = s0_valid | s1_valid | s2_valid;

endmodule
